// File: rtl/banner_reader_if.sv
// Pixel-stream and banner-ROM bus of banner_reader: registered row address out,
// row data back, and a valid/ready pixel stream with row/frame end markers.
interface banner_reader_if #(
    parameter int ROW_W  = 57,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [ROW_W-1:0]  rom_data;
    logic              px_data;
    logic              px_valid;
    logic              px_ready;
    logic              row_done;
    logic              frame_done;

    modport master (
        output rom_addr,
        input  rom_data,
        output px_data,
        output px_valid,
        input  px_ready,
        output row_done,
        output frame_done
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  px_data,
        input  px_valid,
        output px_ready,
        input  row_done,
        input  frame_done
    );
endinterface

// File: rtl/banner_reader.sv
// Banner scanner: fetches NUM_ROWS rows from a registered-output ROM and streams them MSB first.
// Define BANNER_READER_LOOP_EN to rescan continuously instead of returning to IDLE after the last row.
module banner_reader #(
    parameter int ROW_W    = 57,
    parameter int NUM_ROWS = 129,
    parameter int ADDR_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    banner_reader_if.master bus
);

    localparam int unsigned CNT_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(ROW_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [ROW_W-1:0]   shreg;
    logic [ROW_W-1:0]   shreg_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               fire;
    logic               last_bit;
    logic               last_row;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            shreg  <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        fire      = (state == SHIFT) && bus.px_ready;
        last_bit  = (cnt == LAST_BIT);
        last_row  = (addr_q == LAST_ROW);

        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt  = '0;
                    state_nxt = ADDR;
                end
            end
            // ROM samples rom_addr at the end of ADDR; its data is visible during WAIT.
            ADDR: state_nxt = WAIT;
            WAIT: begin
                shreg_nxt = bus.rom_data;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (fire) begin
                    shreg_nxt = shreg << 1;
                    cnt_nxt   = cnt + 1'b1;
                    if (last_bit) begin
                        if (!last_row) begin
                            addr_nxt  = addr_q + 1'b1;
                            state_nxt = ADDR;
                        end else begin
`ifdef BANNER_READER_LOOP_EN
                            addr_nxt  = '0;
                            state_nxt = ADDR;
`else
                            state_nxt = IDLE;
`endif
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are gated by rst_n so nothing is presented or pulsed while reset is held.
    assign bus.rom_addr   = addr_q;
    assign bus.px_valid   = rst_n && (state == SHIFT);
    assign bus.px_data    = bus.px_valid && shreg[ROW_W-1];
    assign bus.row_done   = bus.px_valid && bus.px_ready && last_bit;
    assign bus.frame_done = bus.row_done && last_row;
    assign busy           = rst_n && (state != IDLE);

endmodule

// File: tb/tb_banner_reader.sv
// Scoreboard bench for banner_reader: expected pixel stream queued at each start, checked by a monitor.
// Build with BANNER_READER_LOOP_EN defined to exercise the continuous-scan variant.
module tb_banner_reader;
    localparam int ROW_W    = 57;
    localparam int NUM_ROWS = 129;
    localparam int ADDR_W   = 8;
    localparam int FRAME_PX = ROW_W * NUM_ROWS;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic rdy;

    banner_reader_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) bus ();

    banner_reader #(
        .ROW_W   (ROW_W),
        .NUM_ROWS(NUM_ROWS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_W-1:0] rom_row(input logic [ADDR_W-1:0] r);
        logic [ROW_W-1:0] k;
        k = 57'h1_79B9_7F4A_7C15;
        return {49'h0_AAAA_5555_F0F0, r} ^ (k * ROW_W'(r)) ^ {r, 49'd0};
    endfunction

    // Registered-output ROM: data follows the sampled address by one cycle.
    assign bus.px_ready = rdy;
    always @(posedge clk) bus.rom_data <= rom_row(bus.rom_addr);

    typedef struct packed {
        logic d;
        logic rd;
        logic fd;
    } px_t;

    px_t sbq[$];
    int  checks   = 0;
    int  failures = 0;
    int  acc_cnt  = 0;
    int  rd_cnt   = 0;
    int  fd_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        logic [ROW_W-1:0] w;
        for (int r = 0; r < NUM_ROWS; r++) begin
            w = rom_row(ADDR_W'(r));
            for (int b = ROW_W - 1; b >= 0; b--)
                sbq.push_back('{d: w[b], rd: (b == 0), fd: (b == 0 && r == NUM_ROWS - 1)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that follows the frame_done cycle.
    task automatic wait_frame_done(input int budget, input bit rnd, output bit ok);
        bit seen;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            seen = bus.frame_done;
            @(posedge clk);
            #1;
            if (rnd) rdy = 1'($urandom_range(0, 1));
            if (seen) ok = 1'b1;
        end
        check("frame_done_seen", ok, 1);
    endtask

    always @(negedge clk) begin
        px_t e;
        if (bus.px_valid && rdy) begin
            acc_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_px: got pixel %0b expected none at %0t", bus.px_data, $time);
            end else begin
                e = sbq.pop_front();
                check("px_data", bus.px_data, e.d);
                check("row_done", bus.row_done, e.rd);
                check("frame_done", bus.frame_done, e.fd);
            end
        end else if (bus.px_valid) begin
            if (sbq.size() > 0) check("stall_data", bus.px_data, sbq[0].d);
            check("stall_pulses", {bus.row_done, bus.frame_done}, 0);
        end else begin
            check("idle_pulses", {bus.row_done, bus.frame_done}, 0);
        end
        if (bus.row_done)   rd_cnt++;
        if (bus.frame_done) fd_cnt++;
    end

    initial begin
        bit ok;
        int rd0;
        int fd0;
        int acc0;
        int target;
        logic [ROW_W-1:0] row0;

        row0  = rom_row('0);
        rst_n = 1'b0;
        start = 1'b0;
        rdy   = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_px_valid", bus.px_valid, 0);
        check("rst_px_data", bus.px_data, 0);
        check("rst_pulses", {bus.row_done, bus.frame_done}, 0);
        check("rst_rom_addr", bus.rom_addr, 0);

        rst_n = 1'b1;
        tick();
        check("idle_hold_busy", busy, 0);

        // Frame 1: ready always high, first-row latency and row 0 contents.
        rdy = 1'b1;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_rom_addr", bus.rom_addr, 0);
        check("start_busy", busy, 1);
        check("addr_px_valid", bus.px_valid, 0);
        tick();
        check("wait_px_valid", bus.px_valid, 0);
        tick();
        check("first_px_valid", bus.px_valid, 1);
        check("first_px_data", bus.px_data, row0[ROW_W-1]);
        repeat (ROW_W) tick();
        check("row0_done_cnt", rd_cnt, 1);
        check("row1_rom_addr", bus.rom_addr, 1);
        check("row_gap_px_valid", bus.px_valid, 0);
        wait_frame_done(20000, 1'b0, ok);
        check("frame1_rows", rd_cnt, NUM_ROWS);
        check("frame1_frames", fd_cnt, 1);
        check("frame1_pixels", acc_cnt, FRAME_PX);
        check("frame1_queue_empty", sbq.size(), 0);

`ifdef BANNER_READER_LOOP_EN
        push_frame();
        check("loop_busy", busy, 1);
        check("loop_rom_addr", bus.rom_addr, 0);
        check("loop_addr_px_valid", bus.px_valid, 0);
        tick();
        check("loop_wait_px_valid", bus.px_valid, 0);
        check("loop_busy2", busy, 1);
        tick();
        check("loop_px_valid", bus.px_valid, 1);
        check("loop_px_data", bus.px_data, row0[ROW_W-1]);
        repeat (ROW_W) tick();
        check("loop_row0_done", rd_cnt, NUM_ROWS + 1);
        rst_n = 1'b0;
        sbq.delete();
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        tick();
        check("loop_rst_busy", busy, 0);
        check("loop_rst_px_valid", bus.px_valid, 0);
        rst_n = 1'b1;
        repeat (100) tick();
        check("loop_rst_no_rows", rd_cnt, rd0);
        check("loop_rst_no_frames", fd_cnt, fd0);
`else
        check("busy_after_frame", busy, 0);

        // Frame 2: pseudo-random ready with stalls.
        rd0  = rd_cnt;
        fd0  = fd_cnt;
        acc0 = acc_cnt;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_frame_done(40000, 1'b1, ok);
        rdy = 1'b1;
        check("frame2_rows", rd_cnt - rd0, NUM_ROWS);
        check("frame2_frames", fd_cnt - fd0, 1);
        check("frame2_pixels", acc_cnt - acc0, FRAME_PX);
        check("frame2_queue_empty", sbq.size(), 0);

        // Frame 3: start held high throughout; no mid-frame restart.
        rd0 = rd_cnt;
        push_frame();
        start = 1'b1;
        wait_frame_done(20000, 1'b0, ok);
        check("held_busy_fall", busy, 0);
        check("held_rows", rd_cnt - rd0, NUM_ROWS);
        check("held_queue_empty", sbq.size(), 0);
        push_frame();
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_rom_addr", bus.rom_addr, 0);

        // Abort by reset while pixel 20 of row 5 is presented.
        target = acc_cnt + 5 * ROW_W + 20;
        for (int i = 0; i < 2000 && acc_cnt != target; i++) tick();
        check("reach_row5_px20", acc_cnt, target);
        check("row5_rom_addr", bus.rom_addr, 5);
        rst_n = 1'b0;
        sbq.delete();
        rd0 = rd_cnt;
        fd0 = fd_cnt;
        tick();
        check("abort_px_valid", bus.px_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rom_addr", bus.rom_addr, 0);
        rst_n = 1'b1;
        repeat (200) tick();
        check("abort_no_rows", rd_cnt, rd0);
        check("abort_no_frames", fd_cnt, fd0);
        check("abort_idle", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/banner_reader.md
BANNER_READER -- requirements
Module: banner_reader

Interface
REQ-001 SHALL have parameter ROW_W, default 57: bits per banner row.
REQ-002 SHALL have parameter NUM_ROWS, default 129: rows per frame, indices 0..NUM_ROWS-1.
REQ-003 SHALL have parameter ADDR_W, default 8: row address width.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port start, input, 1: request one frame scan; sampled only in IDLE.
REQ-007 SHALL have port rom_addr, output, ADDR_W: row address to the banner ROM, driven from a register.
REQ-008 SHALL have port rom_data, input, ROW_W: ROM row data, valid one cycle after the ROM samples rom_addr.
REQ-009 SHALL have port px_data, output, 1: current pixel bit, row MSB first.
REQ-010 SHALL have port px_valid, output, 1: px_data valid.
REQ-011 SHALL have port px_ready, input, 1: downstream accepts the pixel when px_valid and px_ready are both high.
REQ-012 SHALL have port row_done, output, 1: one-cycle pulse on acceptance of a row's last pixel.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse on acceptance of the last row's last pixel.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ADDR, WAIT, SHIFT.
REQ-016 IDLE with start=1 SHALL set rom_addr<=0 and go to ADDR; start=0 SHALL hold IDLE.
REQ-017 ADDR SHALL last exactly one cycle, hold rom_addr stable, then go to WAIT.
REQ-018 WAIT SHALL last exactly one cycle: load the shift register with rom_data, clear the bit counter, go to SHIFT.
REQ-019 First px_valid for a row SHALL assert exactly 3 cycles after the edge that sets rom_addr (start-edge, then ADDR, WAIT).
REQ-020 SHIFT SHALL drive px_valid=1 and px_data=shift_reg[ROW_W-1].
REQ-021 On handshake, SHIFT SHALL shift left by one and increment the bit counter.
REQ-022 With px_valid=1 and px_ready=0, px_data and all state SHALL hold unchanged.
REQ-023 Handshake with bit counter = ROW_W-1 SHALL pulse row_done.
REQ-024 In that case with rom_addr < NUM_ROWS-1: rom_addr SHALL increment and the FSM SHALL go to ADDR.
REQ-025 In that case with rom_addr = NUM_ROWS-1: frame_done and row_done SHALL pulse in the same cycle; next state per REQ-031/REQ-032.
REQ-026 start SHALL be ignored while busy=1; no queuing.
REQ-027 px_valid SHALL be 0 in IDLE, ADDR and WAIT; no bubble-free row transition (3-cycle gap between rows).
REQ-028 Frame SHALL deliver exactly NUM_ROWS*ROW_W pixels (7353 at defaults), rows 0..NUM_ROWS-1 in order.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, rom_addr=0, shift register=0, bit counter=0.
REQ-030 Outputs during and after reset SHALL be: px_valid=0, px_data=0, row_done=0, frame_done=0, busy=0. Reset mid-row SHALL abort the frame with no further pixels or pulses.

Configuration
REQ-031 With macro BANNER_READER_LOOP_EN defined, end of the last row SHALL set rom_addr<=0 and go to ADDR, scanning continuously until reset; busy stays 1.
REQ-032 Without BANNER_READER_LOOP_EN, end of the last row SHALL return to IDLE (busy=0 next cycle) and await a new start.

Verification
REQ-033 Reset, then start pulse with px_ready=1 -> rom_addr=0; px_valid rises 3 cycles later; 57 consecutive pixels equal ROM row 0, MSB first; row_done pulses on the 57th.
REQ-034 px_ready toggled pseudo-randomly for a full frame -> 7353 accepted bits match the ROM image; px_data stable whenever valid and not ready; exactly 129 row_done and 1 frame_done pulses.
REQ-035 start held high throughout a frame, macro undefined -> no restart mid-frame; busy falls the cycle after frame_done; next frame begins from row 0.
REQ-036 rst_n=0 on pixel 20 of row 5 -> next cycle px_valid=0, busy=0, rom_addr=0; no row_done or frame_done afterwards.
REQ-037 Macro defined, px_ready=1 -> after frame_done, rom_addr returns to 0 and px_valid reasserts 3 cycles later with row 0 data; busy never drops.
